// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, opcodes,
// instruction classes and halt fault codes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JAL     = 3'd4,
        CLS_JALR    = 3'd5,
        CLS_SYSTEM  = 3'd6,
        CLS_ILLEGAL = 3'd7
    } iclass_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_BUS      = 2'b01;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FLT_MISALIGN = 2'b11;

    function automatic logic [31:0] seq_pc(input logic [31:0] p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/rv_opcode_class.sv
// Combinational opcode classifier: ir[6:0] -> instruction class and illegal flag.
// Zero latency, no state.
module rv_opcode_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] cls,
    output logic       illegal
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_OP,
            OPC_OPIMM,
            OPC_LUI,
            OPC_AUIPC:  cls = CLS_ALU;
            OPC_SYSTEM: cls = CLS_SYSTEM;
            default:    cls = CLS_ILLEGAL;
        endcase
        illegal = (cls == CLS_ILLEGAL);
    end

endmodule

// File: rtl/rv_stage_sequencer.sv
// Multi-cycle stage sequencer for the RV32I core: owns PC, pulses one stage enable per
// cycle, waits on imem/dmem acks (bounded by MEM_TIMEOUT) and halts on faults or SYSTEM.
module rv_stage_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 15,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic [31:0]      alu_out,
    input  logic             branch_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             rf_re,
    output logic             rf_we,
    output logic [31:0]      pc,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_nxt;
    iclass_t     cls_q, cls_dec;
    logic [2:0]  cls_raw;
    logic        dec_illegal;
    logic [7:0]  to_cnt;
    logic        to_hit;
    logic        to_hold;
    logic [31:0] pc_inc;
    logic [31:0] target;
    logic        retire;
    logic        pc_load;
    logic        fault_wr;
    logic [1:0]  fault_nxt;
    logic        unused_ir;

    // Only the opcode and rd fields matter to sequencing.
    assign unused_ir = ^{ir[31:12]};

    rv_opcode_class u_cls (
        .opcode  (ir[6:0]),
        .cls     (cls_raw),
        .illegal (dec_illegal)
    );

    assign cls_dec = iclass_t'(cls_raw);
    assign pc_inc  = seq_pc(pc);
    assign to_hit  = (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        if_en     = 1'b0;
        id_en     = 1'b0;
        ex_en     = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        rf_re     = 1'b0;
        rf_we     = 1'b0;
        halted    = 1'b0;
        retire    = 1'b0;
        pc_load   = 1'b0;
        fault_wr  = 1'b0;
        fault_nxt = FLT_NONE;
        target    = pc_inc;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_load   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if_en     = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (to_hit) begin
                    fault_wr  = 1'b1;
                    fault_nxt = FLT_BUS;
                    state_nxt = ST_HALT;
                end
            end
            ST_DECODE: begin
                id_en = 1'b1;
                rf_re = 1'b1;
                if (dec_illegal) begin
                    fault_wr  = 1'b1;
                    fault_nxt = FLT_ILLEGAL;
                    state_nxt = ST_HALT;
                end else if (cls_dec == CLS_SYSTEM) begin
                    fault_wr  = 1'b1;
                    fault_nxt = FLT_NONE;
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                ex_en = 1'b1;
                case (cls_q)
                    CLS_LOAD, CLS_STORE: state_nxt = ST_MEMORY;
                    CLS_BRANCH: begin
                        target = branch_taken ? alu_out : pc_inc;
                        if (branch_taken && (alu_out[1:0] != 2'b00)) begin
                            fault_wr  = 1'b1;
                            fault_nxt = FLT_MISALIGN;
                            state_nxt = ST_HALT;
                        end else begin
                            retire    = 1'b1;
                            state_nxt = ST_FETCH;
                        end
                    end
                    default: state_nxt = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_STORE);
                if (dmem_ack) begin
                    mem_en = 1'b1;
                    if (cls_q == CLS_STORE) begin
                        retire    = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_WRITEBACK;
                    end
                end else if (to_hit) begin
                    fault_wr  = 1'b1;
                    fault_nxt = FLT_BUS;
                    state_nxt = ST_HALT;
                end
            end
            ST_WRITEBACK: begin
                wb_en = 1'b1;
                // The link register is written even when the jump target faults.
                rf_we = (ir[11:7] != 5'd0);
                if (cls_q == CLS_JAL) begin
                    target = alu_out;
                end else if (cls_q == CLS_JALR) begin
                    target = {alu_out[31:1], 1'b0};
                end
                if (((cls_q == CLS_JAL) || (cls_q == CLS_JALR)) && (target[1:0] != 2'b00)) begin
                    fault_wr  = 1'b1;
                    fault_nxt = FLT_MISALIGN;
                    state_nxt = ST_HALT;
                end else begin
                    retire    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Timeout counter runs only while a request stays outstanding in the same state.
    assign to_hold = (state_nxt == state) && ((state == ST_FETCH) || (state == ST_MEMORY));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            cls_q     <= CLS_ALU;
            fault     <= FLT_NONE;
            to_cnt    <= 8'd0;
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (pc_load) begin
                pc <= RESET_PC;
            end else if (retire) begin
                pc <= target;
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
            if (state == ST_DECODE) begin
                cls_q <= cls_dec;
            end
            if (fault_wr) begin
                fault <= fault_nxt;
            end
            to_cnt <= to_hold ? (to_cnt + 8'd1) : 8'd0;
            if ((state != ST_IDLE) && (state != ST_HALT)) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_stage_sequencer.sv
// Directed bench for rv_stage_sequencer: drives and samples on the falling edge,
// expected values hand-computed from the instruction timing.
module tb_rv_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] ir = 32'h0;
    logic [31:0] alu_out = 32'h0;
    logic        branch_taken = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we;
    logic        if_en, id_en, ex_en, mem_en, wb_en;
    logic        rf_re, rf_we;
    logic [31:0] pc;
    logic        halted;
    logic [1:0]  fault;
    logic [31:0] cycle_cnt, instret;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rv_stage_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .MEM_TIMEOUT (15),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ir           (ir),
        .alu_out      (alu_out),
        .branch_taken (branch_taken),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .if_en        (if_en),
        .id_en        (id_en),
        .ex_en        (ex_en),
        .mem_en       (mem_en),
        .wb_en        (wb_en),
        .rf_re        (rf_re),
        .rf_we        (rf_we),
        .pc           (pc),
        .halted       (halted),
        .fault        (fault),
        .cycle_cnt    (cycle_cnt),
        .instret      (instret)
    );

    wire [4:0] stage_en = {if_en, id_en, ex_en, mem_en, wb_en};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst          = 1'b0;
        start        = 1'b0;
        imem_ack     = 1'b1;
        dmem_ack     = 1'b0;
        branch_taken = 1'b0;
        alu_out      = 32'h0;
        tick;
        tick;
        rst = 1'b1;
        tick;
    endtask

    // Leaves the bench at the falling edge of the first FETCH cycle.
    task automatic launch;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        int n;

        // Reset state
        do_reset;
        check("rst_pc", pc, 32'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 2'b00);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_reqs", {imem_req, dmem_req, dmem_we}, 3'b000);
        check("rst_en", stage_en, 5'b00000);

        // addi x1,x0,5 with zero-wait fetch
        ir = 32'h00500093;
        launch;
        check("addi_f_en", stage_en, 5'b10000);
        check("addi_f_req", imem_req, 1'b1);
        tick;
        check("addi_d_en", stage_en, 5'b01000);
        check("addi_d_rfre", rf_re, 1'b1);
        tick;
        check("addi_e_en", stage_en, 5'b00100);
        tick;
        check("addi_w_en", stage_en, 5'b00001);
        check("addi_w_rfwe", rf_we, 1'b1);
        check("addi_w_pc", pc, 32'h0);
        tick;
        check("addi_pc", pc, 32'h4);
        check("addi_instret", instret, 32'd1);
        check("addi_cycle", cycle_cnt, 32'd4);

        // lw x1,0(x0) with dmem_ack three cycles late
        do_reset;
        ir = 32'h00002083;
        launch;
        tick;
        tick;
        tick;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            #1;
            if (dmem_req) n++;
            check("lw_mem_en", mem_en, (i == 3) ? 32'd1 : 32'd0);
            if (i == 0) check("lw_we", dmem_we, 1'b0);
            tick;
        end
        dmem_ack = 1'b0;
        check("lw_req_cycles", n, 32'd4);
        check("lw_w_en", stage_en, 5'b00001);
        check("lw_w_rfwe", rf_we, 1'b1);
        tick;
        check("lw_pc", pc, 32'h4);
        check("lw_instret", instret, 32'd1);
        check("lw_cycle", cycle_cnt, 32'd8);

        // Taken branch to 0x40
        do_reset;
        ir = 32'h00000063;
        branch_taken = 1'b1;
        alu_out = 32'h40;
        launch;
        tick;
        tick;
        check("br_e_en", stage_en, 5'b00100);
        check("br_rfwe", rf_we, 1'b0);
        tick;
        check("br_pc", pc, 32'h40);
        check("br_instret", instret, 32'd1);
        check("br_cycle", cycle_cnt, 32'd3);

        // jalr x1,0(x1) with odd target: bit 0 cleared
        do_reset;
        ir = 32'h000080e7;
        alu_out = 32'h41;
        launch;
        tick;
        tick;
        tick;
        check("jalr_rfwe", rf_we, 1'b1);
        tick;
        check("jalr_pc", pc, 32'h40);
        check("jalr_instret", instret, 32'd1);

        // Illegal opcode; start must not restart a halted core
        do_reset;
        ir = 32'h0000007f;
        launch;
        tick;
        check("ill_d_halted", halted, 1'b0);
        tick;
        check("ill_halted", halted, 1'b1);
        check("ill_fault", fault, 2'b10);
        check("ill_pc", pc, 32'h0);
        check("ill_instret", instret, 32'd0);
        start = 1'b1;
        tick;
        tick;
        start = 1'b0;
        check("ill_stay", halted, 1'b1);
        check("ill_cycle", cycle_cnt, 32'd2);
        check("ill_idle_out", {imem_req, stage_en}, 6'b000000);

        // ecall: clean halt
        do_reset;
        ir = 32'h00000073;
        launch;
        tick;
        tick;
        check("ecall_halted", halted, 1'b1);
        check("ecall_fault", fault, 2'b00);
        check("ecall_instret", instret, 32'd0);

        // Fetch timeout
        do_reset;
        imem_ack = 1'b0;
        ir = 32'h00500093;
        launch;
        n = 0;
        repeat (40) begin
            if (imem_req) n++;
            tick;
        end
        check("to_req_cycles", n, 32'd15);
        check("to_halted", halted, 1'b1);
        check("to_fault", fault, 2'b01);
        check("to_cycle", cycle_cnt, 32'd15);

        // Taken branch to misaligned target
        do_reset;
        ir = 32'h00000063;
        branch_taken = 1'b1;
        alu_out = 32'h42;
        launch;
        tick;
        tick;
        tick;
        check("mis_br_halted", halted, 1'b1);
        check("mis_br_fault", fault, 2'b11);
        check("mis_br_pc", pc, 32'h0);
        check("mis_br_instret", instret, 32'd0);

        // jal x1 to misaligned target still writes the link register
        do_reset;
        ir = 32'h000000ef;
        alu_out = 32'h42;
        launch;
        tick;
        tick;
        tick;
        check("mis_jal_rfwe", rf_we, 1'b1);
        tick;
        check("mis_jal_fault", fault, 2'b11);
        check("mis_jal_pc", pc, 32'h0);

        // Async reset in the middle of a store's MEMORY wait
        do_reset;
        ir = 32'h00102023;
        launch;
        tick;
        tick;
        tick;
        check("sw_req", {dmem_req, dmem_we}, 2'b11);
        check("sw_cycle_pre", cycle_cnt, 32'd3);
        #2 rst = 1'b0;
        #1;
        check("arst_req", dmem_req, 1'b0);
        check("arst_cycle", cycle_cnt, 32'd0);
        check("arst_pc", pc, 32'h0);
        tick;
        check("arst_idle", {imem_req, halted}, 2'b00);
        rst = 1'b1;
        tick;

        // Zero-wait store retires in 4 cycles
        dmem_ack = 1'b1;
        launch;
        tick;
        tick;
        tick;
        check("sw_m_en", stage_en, 5'b00010);
        tick;
        check("sw_pc", pc, 32'h4);
        check("sw_instret", instret, 32'd1);
        check("sw_cycle", cycle_cnt, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
